// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one synchronous memory port between instruction fetch and data
//   load/store. Data normally wins; after MAX_DATA_STREAK consecutive losses
//   fetch is forced through. Every issued read is tracked by a LOAD_LATENCY
//   deep tag pipeline so the returning mem_rdata is flagged for the right
//   consumer. A flush kills fetch tags already in flight.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   fet_req/fet_addr      fetch read request        -> fet_gnt, fet_valid
//   dat_req/dat_we/...    data load/store request   -> dat_gnt, dat_valid
//   mem_*                 memory port (mem_rdata returns LOAD_LATENCY later)
//   rd_data               mem_rdata passthrough
//   stall_pc              fetch requested but not granted
//   flush                 kill in-flight fetch returns
//   stat_fet_stall/stat_dat_gnt  activity counters
//
// Optional feature: define MEM_ARB_STATS_EN to build saturating 32-bit
// counters of stall_pc cycles and dat_gnt cycles; otherwise both ports are 0.

`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef DATA_W
`define DATA_W 64
`endif

module mem_port_arbiter #(
    parameter int LOAD_LATENCY    = 1,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fet_req,
    input  logic [`ADDR_W-1:0]  fet_addr,
    output logic                fet_gnt,
    output logic                fet_valid,
    input  logic                dat_req,
    input  logic                dat_we,
    input  logic [`ADDR_W-1:0]  dat_addr,
    input  logic [`DATA_W-1:0]  dat_wdata,
    input  logic [7:0]          dat_wstrb,
    output logic                dat_gnt,
    output logic                dat_valid,
    output logic                mem_en,
    output logic                mem_we,
    output logic [`ADDR_W-1:0]  mem_addr,
    output logic [`DATA_W-1:0]  mem_wdata,
    output logic [7:0]          mem_wstrb,
    input  logic [`DATA_W-1:0]  mem_rdata,
    output logic [`DATA_W-1:0]  rd_data,
    output logic                stall_pc,
    input  logic                flush,
    output logic [31:0]         stat_fet_stall,
    output logic [31:0]         stat_dat_gnt
);

    localparam int SW   = $clog2(MAX_DATA_STREAK + 1);
    localparam int LAST = LOAD_LATENCY - 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

    logic [SW-1:0]           streak_q, streak_d;
    logic [LOAD_LATENCY-1:0] tag_v_q,    tag_v_d;
    logic [LOAD_LATENCY-1:0] tag_src_q,  tag_src_d;
    logic [LOAD_LATENCY-1:0] tag_kill_q, tag_kill_d;
    logic                    force_fet;

    // Grant: data has priority unless fetch has lost MAX_DATA_STREAK times.
    // Grants are suppressed while reset is held.
    always_comb begin
        force_fet = (streak_q == STREAK_MAX);
        dat_gnt   = ~rst & dat_req & ~(fet_req & force_fet);
        fet_gnt   = ~rst & fet_req & ~dat_gnt;
    end

    assign stall_pc = fet_req & ~fet_gnt;
    assign mem_en   = fet_gnt | dat_gnt;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (dat_gnt) begin
            mem_we    = dat_we;
            mem_addr  = dat_addr;
            mem_wdata = dat_wdata;
            mem_wstrb = dat_wstrb;
        end else if (fet_gnt) begin
            mem_addr  = fet_addr;
        end
    end

    always_comb begin
        streak_d = streak_q;
        if (!fet_req || fet_gnt) begin
            streak_d = '0;
        end else if (dat_gnt && streak_q != STREAK_MAX) begin
            streak_d = streak_q + 1'b1;
        end
    end

    // Tag pipeline. Stores take no tag. On flush, every fetch tag moving
    // between stages picks up kill; the tag entering stage 0 this edge is
    // the redirected fetch and stays live.
    always_comb begin
        tag_v_d       = '0;
        tag_src_d     = '0;
        tag_kill_d    = '0;
        tag_v_d[0]    = fet_gnt | (dat_gnt & ~dat_we);
        tag_src_d[0]  = dat_gnt;
        tag_kill_d[0] = 1'b0;
        for (int i = 1; i < LOAD_LATENCY; i++) begin
            tag_v_d[i]    = tag_v_q[i-1];
            tag_src_d[i]  = tag_src_q[i-1];
            tag_kill_d[i] = tag_kill_q[i-1] |
                            (flush & tag_v_q[i-1] & ~tag_src_q[i-1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_q   <= '0;
            tag_v_q    <= '0;
            tag_kill_q <= '0;
        end else begin
            streak_q   <= streak_d;
            tag_v_q    <= tag_v_d;
            tag_kill_q <= tag_kill_d;
        end
    end

    // src is only meaningful alongside v, so it needs no reset.
    always_ff @(posedge clk) begin
        tag_src_q <= tag_src_d;
    end

    // Return decode: fet_valid shows the pre-flush kill of the last stage.
    assign fet_valid = tag_v_q[LAST] & ~tag_src_q[LAST] & ~tag_kill_q[LAST];
    assign dat_valid = tag_v_q[LAST] &  tag_src_q[LAST];
    assign rd_data   = mem_rdata;

`ifdef MEM_ARB_STATS_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic en);
        sat_inc = (en && cnt != 32'hFFFF_FFFF) ? cnt + 32'd1 : cnt;
    endfunction

    logic [31:0] stat_fet_stall_q, stat_dat_gnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_fet_stall_q <= '0;
            stat_dat_gnt_q   <= '0;
        end else begin
            stat_fet_stall_q <= sat_inc(stat_fet_stall_q, stall_pc);
            stat_dat_gnt_q   <= sat_inc(stat_dat_gnt_q, dat_gnt);
        end
    end

    assign stat_fet_stall = stat_fet_stall_q;
    assign stat_dat_gnt   = stat_dat_gnt_q;
`else
    assign stat_fet_stall = '0;
    assign stat_dat_gnt   = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef DATA_W
`define DATA_W 64
`endif

module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    // Instance u1: LOAD_LATENCY=1, MAX_DATA_STREAK=4
    logic               rst1, f_req1, d_req1, d_we1, flush1;
    logic [`ADDR_W-1:0] f_addr1, d_addr1;
    logic [`DATA_W-1:0] d_wdata1, rdata1;
    logic [7:0]         d_wstrb1;
    logic               f_gnt1, f_vld1, d_gnt1, d_vld1, m_en1, m_we1, stall1;
    logic [`ADDR_W-1:0] m_addr1;
    logic [`DATA_W-1:0] m_wdata1, rd1;
    logic [7:0]         m_wstrb1;
    logic [31:0]        st_fs1, st_dg1;

    // Instance u3: LOAD_LATENCY=3, MAX_DATA_STREAK=4
    logic               rst3, f_req3, d_req3, d_we3, flush3;
    logic [`ADDR_W-1:0] f_addr3, d_addr3;
    logic [`DATA_W-1:0] d_wdata3, rdata3;
    logic [7:0]         d_wstrb3;
    logic               f_gnt3, f_vld3, d_gnt3, d_vld3, m_en3, m_we3, stall3;
    logic [`ADDR_W-1:0] m_addr3;
    logic [`DATA_W-1:0] m_wdata3, rd3;
    logic [7:0]         m_wstrb3;
    logic [31:0]        st_fs3, st_dg3;

    mem_port_arbiter #(.LOAD_LATENCY(1), .MAX_DATA_STREAK(4)) u1 (
        .clk(clk), .rst(rst1),
        .fet_req(f_req1), .fet_addr(f_addr1), .fet_gnt(f_gnt1), .fet_valid(f_vld1),
        .dat_req(d_req1), .dat_we(d_we1), .dat_addr(d_addr1), .dat_wdata(d_wdata1),
        .dat_wstrb(d_wstrb1), .dat_gnt(d_gnt1), .dat_valid(d_vld1),
        .mem_en(m_en1), .mem_we(m_we1), .mem_addr(m_addr1), .mem_wdata(m_wdata1),
        .mem_wstrb(m_wstrb1), .mem_rdata(rdata1), .rd_data(rd1),
        .stall_pc(stall1), .flush(flush1),
        .stat_fet_stall(st_fs1), .stat_dat_gnt(st_dg1)
    );

    mem_port_arbiter #(.LOAD_LATENCY(3), .MAX_DATA_STREAK(4)) u3 (
        .clk(clk), .rst(rst3),
        .fet_req(f_req3), .fet_addr(f_addr3), .fet_gnt(f_gnt3), .fet_valid(f_vld3),
        .dat_req(d_req3), .dat_we(d_we3), .dat_addr(d_addr3), .dat_wdata(d_wdata3),
        .dat_wstrb(d_wstrb3), .dat_gnt(d_gnt3), .dat_valid(d_vld3),
        .mem_en(m_en3), .mem_we(m_we3), .mem_addr(m_addr3), .mem_wdata(m_wdata3),
        .mem_wstrb(m_wstrb3), .mem_rdata(rdata3), .rd_data(rd3),
        .stall_pc(stall3), .flush(flush3),
        .stat_fet_stall(st_fs3), .stat_dat_gnt(st_dg3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic exp_d, exp_f, prev_d, prev_f;
    logic [31:0] exp_stat;

    initial begin
        rst1 = 1'b1; f_req1 = 1'b0; d_req1 = 1'b0; d_we1 = 1'b0; flush1 = 1'b0;
        f_addr1 = '0; d_addr1 = '0; d_wdata1 = '0; d_wstrb1 = '0; rdata1 = '0;
        rst3 = 1'b1; f_req3 = 1'b0; d_req3 = 1'b0; d_we3 = 1'b0; flush3 = 1'b0;
        f_addr3 = '0; d_addr3 = '0; d_wdata3 = '0; d_wstrb3 = '0; rdata3 = 64'hABCD;

        // Reset: grants forced low, stall_pc follows fet_req, no returns.
        f_req1 = 1'b1;
        tick();
        chk("rst_fet_gnt", f_gnt1, 0);
        chk("rst_mem_en", m_en1, 0);
        chk("rst_stall_pc", stall1, 1);
        chk("rst_fet_valid", f_vld1, 0);
        chk("rst_dat_valid", d_vld1, 0);
        chk("rst_stat_dat", st_dg1, 0);
        f_req1 = 1'b0;
        tick();
        rst1 = 1'b0; rst3 = 1'b0;
        tick();

        // Single fetch, latency 1.
        f_req1 = 1'b1; f_addr1 = 32'h10;
        #1;
        chk("f1_fet_gnt", f_gnt1, 1);
        chk("f1_mem_en", m_en1, 1);
        chk("f1_mem_addr", m_addr1, 64'h10);
        chk("f1_mem_we", m_we1, 0);
        chk("f1_stall", stall1, 0);
        tick();
        f_req1 = 1'b0; rdata1 = 64'h1111_2222_3333_4444;
        #1;
        chk("f1_fet_valid", f_vld1, 1);
        chk("f1_dat_valid", d_vld1, 0);
        chk("f1_rd_data", rd1, 64'h1111_2222_3333_4444);
        chk("f1_idle_mem_en", m_en1, 0);
        tick();

        // Contention: data wins 4 cycles, fetch forced on the 5th.
        f_req1 = 1'b1; f_addr1 = 32'h10;
        d_req1 = 1'b1; d_we1 = 1'b0; d_addr1 = 32'h40; d_wstrb1 = 8'hFF;
        prev_d = 1'b0; prev_f = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            exp_d = (c % 5) != 4;
            exp_f = (c % 5) == 4;
            chk($sformatf("ct%0d_dat_gnt", c), d_gnt1, exp_d);
            chk($sformatf("ct%0d_fet_gnt", c), f_gnt1, exp_f);
            chk($sformatf("ct%0d_stall", c), stall1, exp_d);
            chk($sformatf("ct%0d_addr", c), m_addr1, exp_d ? 64'h40 : 64'h10);
            chk($sformatf("ct%0d_dat_valid", c), d_vld1, prev_d);
            chk($sformatf("ct%0d_fet_valid", c), f_vld1, prev_f);
            if (exp_f) begin
                chk($sformatf("ct%0d_fet_wstrb", c), m_wstrb1, 0);
                chk($sformatf("ct%0d_fet_we", c), m_we1, 0);
            end
            prev_d = exp_d; prev_f = exp_f;
            tick();
        end
        f_req1 = 1'b0; d_req1 = 1'b0; d_wstrb1 = 8'h00;
        #1;
        chk("ct_end_fet_valid", f_vld1, 1);
        chk("ct_end_dat_valid", d_vld1, 0);
        chk("idle_mem_en", m_en1, 0);
        chk("idle_mem_addr", m_addr1, 0);
        chk("idle_stall", stall1, 0);
`ifdef MEM_ARB_STATS_EN
        exp_stat = 32'd8;
`else
        exp_stat = 32'd0;
`endif
        chk("stat_dat_gnt", st_dg1, exp_stat);
        chk("stat_fet_stall", st_fs1, exp_stat);
        tick();

        // Store: written through, never returns data.
        d_req1 = 1'b1; d_we1 = 1'b1; d_addr1 = 32'h80;
        d_wdata1 = 64'hDEADBEEF; d_wstrb1 = 8'h0F;
        #1;
        chk("st_dat_gnt", d_gnt1, 1);
        chk("st_mem_we", m_we1, 1);
        chk("st_mem_wstrb", m_wstrb1, 8'h0F);
        chk("st_mem_wdata", m_wdata1, 64'hDEADBEEF);
        chk("st_mem_addr", m_addr1, 64'h80);
        tick();
        d_req1 = 1'b0; d_we1 = 1'b0;
        #1;
        chk("st_no_dat_valid1", d_vld1, 0);
        tick();
        chk("st_no_dat_valid2", d_vld1, 0);

        // Latency 3 flush: F0,F1 in flight; F2 is the redirect fetch issued
        // in the flush cycle; F3 follows.
        f_req3 = 1'b1; f_addr3 = 32'h100;
        #1;
        chk("fl_a0_gnt", f_gnt3, 1);
        tick();
        f_addr3 = 32'h104;
        tick();
        f_addr3 = 32'h200; flush3 = 1'b1;
        #1;
        chk("fl_a2_gnt", f_gnt3, 1);
        chk("fl_a2_fet_valid", f_vld3, 0);
        tick();
        flush3 = 1'b0; f_addr3 = 32'h204;
        #1;
        chk("fl_ret_f0", f_vld3, 0);
        tick();
        f_req3 = 1'b0;
        #1;
        chk("fl_ret_f1", f_vld3, 0);
        tick();
        chk("fl_ret_f2", f_vld3, 1);
        chk("fl_ret_f2_rd", rd3, 64'hABCD);
        tick();
        chk("fl_ret_f3", f_vld3, 1);
        chk("fl_dat_valid", d_vld3, 0);
        tick();
        chk("fl_drained", f_vld3, 0);

        // Reset mid-operation: load in flight is discarded, streak cleared.
        f_req3 = 1'b1; d_req3 = 1'b1; d_we3 = 1'b0; d_addr3 = 32'h40; f_addr3 = 32'h300;
        #1;
        chk("rs_load_gnt", d_gnt3, 1);
        tick();
        d_req3 = 1'b0; rst3 = 1'b1;
        #1;
        chk("rs_fet_gnt", f_gnt3, 0);
        chk("rs_mem_en", m_en3, 0);
        chk("rs_stall", stall3, 1);
        tick();
        rst3 = 1'b0; d_req3 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("rs%0d_dat_gnt", c), d_gnt3, c < 4);
            chk($sformatf("rs%0d_fet_gnt", c), f_gnt3, c == 4);
            chk($sformatf("rs%0d_dat_valid", c), d_vld3, c >= 3);
            tick();
        end
        f_req3 = 1'b0; d_req3 = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
